// File: rtl/instr_sequencer.sv
// instr_sequencer: program-driven instruction source for datapath.
// Fetches 16-bit words from a synchronous instruction memory (one-cycle read
// latency), issues one per cycle on opCode, and drives NOP_WORD when idle or
// halted. Also registers the datapath flags and derives cin from them.
// Optional feature macro: SEQ_ICOUNT_EN (compiles in the issued-instruction
// counter; when undefined instr_count is tied to zero).
module instr_sequencer #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [15:0]           HALT_WORD  = 16'h0000,
  parameter logic [15:0]           NOP_WORD   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  imem_rd,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [15:0]           imem_rdata,
  input  logic [4:0]            flags_in,
  output logic [15:0]           opCode,
  output logic [4:0]            flags,
  output logic                  cin,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic [15:0]           instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [15:0]           opcode_q, opcode_d;
  logic [4:0]            flags_q, flags_d;
  logic                  fetch;
  logic                  halt_hit;

  // Fetch strobe follows run directly so the first read leaves in the same
  // cycle run rises; it is forced low while reset is held so the memory sees
  // no read during reset even with run high.
  assign fetch    = run && !reset && (state_q != S_HALT);
  // A read issued last cycle has returned the halt word this cycle.
  assign halt_hit = rd_pending_q && (imem_rdata == HALT_WORD);

  // Next-state, PC advance, issue and flag capture.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rd_pending_d = fetch;
    opcode_d     = NOP_WORD;
    flags_d      = flags_in;

    case (state_q)
      S_IDLE:  if (run) state_d = S_RUN;
      S_RUN:   if (!run) state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (fetch) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end

    if (halt_hit) begin
      // The read issued alongside the halt word is dropped; pc keeps its
      // advanced value.
      state_d      = S_HALT;
      rd_pending_d = 1'b0;
    end else if (rd_pending_q) begin
      opcode_d = imem_rdata;
    end
  end

  // State, PC, pending-read, issue and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= START_ADDR;
      rd_pending_q <= 1'b0;
      opcode_q     <= NOP_WORD;
      flags_q      <= 5'b00000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_pending_q <= rd_pending_d;
      opcode_q     <= opcode_d;
      flags_q      <= flags_d;
    end
  end

`ifdef SEQ_ICOUNT_EN
  logic [15:0] icount_q, icount_d;

  // Saturating count of words actually issued on opCode.
  always_comb begin
    icount_d = icount_q;
    if (rd_pending_q && !halt_hit && (icount_q != 16'hFFFF)) begin
      icount_d = icount_q + 16'd1;
    end
  end

  // Issued-instruction counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icount_q <= 16'h0000;
    end else begin
      icount_q <= icount_d;
    end
  end

  assign instr_count = icount_q;
`else
  assign instr_count = 16'h0000;
`endif

  assign imem_rd   = fetch;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opCode    = opcode_q;
  assign flags     = flags_q;
  assign cin       = flags_q[3];
  assign halted    = (state_q == S_HALT);

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program-driven instruction source for `datapath`, replacing hard-coded opcode stepping. Fetches 16-bit instruction words from a synchronous instruction ROM/RAM, issues one per cycle on `opCode`, and inserts NOPs when idle or halted. It also registers the datapath flags and derives `cin` from them. It sits directly upstream of `datapath`; `rout` and the display path are unchanged.

## Interface
- `ADDR_WIDTH`, default 8: instruction address width; program space is 2^ADDR_WIDTH words.
- `START_ADDR`, default 0: PC value after reset.
- `HALT_WORD`, default 16'h0000: a fetched word equal to this halts the sequencer.
- `NOP_WORD`, default 16'h0000: value driven on `opCode` whenever no instruction is issued.
- `clk`: input, 1 bit. Clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `run`: input, 1 bit. Level-sensitive fetch enable.
- `imem_rd`: output, 1 bit. Read strobe to instruction memory.
- `imem_addr`: output, ADDR_WIDTH bits. Read address; equals `pc`.
- `imem_rdata`: input, 16 bits. Read data, valid exactly one cycle after `imem_rd`.
- `flags_in`: input, 5 bits. Datapath flag outputs.
- `opCode`: output, 16 bits, registered. Instruction to `datapath`.
- `flags`: output, 5 bits, registered. Latched `flags_in`.
- `cin`: output, 1 bit. Equals `flags[3]`.
- `pc`: output, ADDR_WIDTH bits. Program counter.
- `halted`: output, 1 bit. High in HALT state.
- `instr_count`: output, 16 bits. Count of issued instructions.

## Operation
- States:
  - IDLE: no fetch.
  - RUN: fetch every cycle.
  - HALT: no fetch; sticky.
- Reset values:
  - state = IDLE; `pc` = START_ADDR; `opCode` = NOP_WORD.
  - `flags` = 0, so `cin` = 0; `halted` = 0; `instr_count` = 0.
  - internal `rd_pending` = 0; `imem_rd` = 0.
- Transitions:
  - IDLE → RUN when `run`=1.
  - RUN → IDLE when `run`=0.
  - RUN or IDLE → HALT when a pending fetch returns HALT_WORD.
  - HALT exits only via `reset`.
- Fetch:
  - In RUN, `imem_rd`=1 and `imem_addr`=`pc`; `pc` advances by 1 that edge.
  - `pc` wraps from all-ones to 0 and continues.
  - `rd_pending` is set to `imem_rd` each edge.
- Issue, at each edge:
  - If `rd_pending` and `imem_rdata` ≠ HALT_WORD: `opCode` ← `imem_rdata` and `instr_count` increments.
  - Otherwise `opCode` ← NOP_WORD.
- Halt:
  - On HALT_WORD, `opCode` ← NOP_WORD and state ← HALT.
  - `rd_pending` is cleared, so the fetch issued in that same cycle is discarded and never reaches `opCode`.
  - `pc` stays at the value it had advanced to.
- `run` dropped mid-stream: the in-flight fetch still issues normally, then NOPs follow. When `run` returns, fetch resumes at the current `pc` with no skip and no repeat.
- Flags: `flags` ← `flags_in` every edge in every state; `cin` = `flags[3]` combinationally from that register.
- `instr_count` saturates at 16'hFFFF.

## Timing
- Latency from `imem_rd` in cycle t to `opCode` valid in cycle t+2 is 2 cycles.
- Throughput is 1 instruction per cycle in steady RUN; no bubbles between consecutive non-halt words.
- First instruction after `run` rises in cycle t: `imem_rd` is high in t and `opCode` is valid in t+2.
- `halted` rises the cycle after the HALT_WORD data cycle, together with the NOP on `opCode`.
- Asynchronous `reset` mid-stream: all outputs return to reset values immediately. Any in-flight read data is ignored; `rd_pending` is already 0.
- `flags`/`cin` lag `flags_in` by one cycle.

## Configuration
- Macro: `SEQ_ICOUNT_EN`.
  - Defined: the `instr_count` register and increment logic are compiled in as described.
  - Undefined: no counter logic; `instr_count` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset then `run`=1, memory[0..2] = 16'h5001, 16'h5101, 16'h0151, memory[3] = 16'h0000.
  - `opCode` shows 5001, 5101, 0151 on consecutive cycles starting 2 cycles after the first `imem_rd`.
  - Then `opCode` = NOP and `halted`=1.
  - `pc`=5, `instr_count`=3.
- `run`=0 for 3 cycles after 2 fetches, then `run`=1.
  - The in-flight word still issues, followed by 3 NOPs.
  - Fetch resumes at the next address; no duplicate or dropped word.
- ADDR_WIDTH=2, memory all nonzero, `run` held.
  - `pc` sequence is 0, 1, 2, 3, 0, 1…
  - `opCode` repeats the 4 words in order.
- `flags_in` = 5'b01000 for one cycle.
  - The next cycle shows `flags`=5'b01000 and `cin`=1.
  - The following cycle shows `cin`=0 once `flags_in` returns to 0.
- Assert `reset` asynchronously mid-stream between clock edges.
  - `opCode`=NOP, `pc`=START_ADDR, `halted`=0 and `imem_rd`=0 immediately.
  - `run` still high after release: fetch restarts at START_ADDR.
- HALT_WORD reached, then `run` toggled.
  - `halted` remains 1, `imem_rd` stays 0 and `opCode` stays NOP until `reset`.
  - `instr_count` reads 16'h0000 when `SEQ_ICOUNT_EN` is undefined.
